cheater_text_overlay: RTL
=========================

Name: cheater_text_overlay

Overview:
- Pipelined VGA overlay stage that sits between the VGA timing/background chain and the output mux.
- Converts pixel position into character coordinates and drives char_xy to the cheater char ROM.
- Combines the returned char_code with the text line into a font ROM address, then paints lit font pixels over rgb_in.
- A frame-based typewriter controller reveals the message one character at a time.

Parameters:
- XPOS, 100, left pixel column of the text box.
- YPOS, 100, top pixel row of the text box.
- COLS, 30, number of character columns (ROM column index 0..COLS-1).
- ROWS, 1, number of character rows.
- TEXT_COLOR, 12'hF00, RGB444 colour of lit font pixels.
- REVEAL_FRAMES, 4, frames per newly revealed character (minimum 1).

Ports:
- pclk  in  1  pixel clock.
- rst  in  1  asynchronous active-high reset.
- enable  in  1  show/animate text when high.
- hcount_in  in  11  horizontal pixel count.
- hsync_in  in  1  horizontal sync.
- hblnk_in  in  1  horizontal blank.
- vcount_in  in  11  vertical line count.
- vsync_in  in  1  vertical sync.
- vblnk_in  in  1  vertical blank.
- rgb_in  in  12  background pixel.
- char_code  in  7  from char ROM, combinational response to char_xy.
- char_pixels  in  8  from font ROM, registered one cycle after font_addr; bit 7 is the leftmost pixel.
- char_xy  out  16  {column[7:0], row[7:0]} to the char ROM.
- font_addr  out  11  {char_code, char_line[3:0]} to the font ROM.
- hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out  out  11/1/1/11/1/1  timing delayed by 3 cycles.
- rgb_out  out  12  overlaid pixel, aligned with the delayed timing.

Behaviour:
- Reset: all outputs, pipeline registers and FSM return to 0 / IDLE.
- Geometry: a character cell is 8x16 pixels.
  - In box when XPOS <= hcount < XPOS+8*COLS and YPOS <= vcount < YPOS+16*ROWS.
  - rel_x = hcount-XPOS; rel_y = vcount-YPOS.
  - column = rel_x[10:3]; px = rel_x[2:0]; row = rel_y[11:4]; char_line = rel_y[3:0].
- Stage 1 (cycle +1): register timing and rgb_in, in_box, px, char_line, column; register char_xy. When out of box, char_xy = 0.
- Stage 2 (cycle +2): register font_addr = {char_code, char_line}; carry in_box, px, column and timing.
- Stage 3 (cycle +3): char_pixels is valid. rgb_out = TEXT_COLOR if in_box && visible(column) && char_pixels[7-px], else the delayed rgb_in. Blanked pixels (hblnk or vblnk delayed) output 12'h000.
- Fixed latency: 3 cycles for every timing output and rgb_out.
- Reveal FSM, with a frame tick on each rising edge of vblnk_in:
  - IDLE: revealed=0, frame_cnt=0. Nothing is visible. Goes to REVEAL when enable=1.
  - REVEAL: frame_cnt counts ticks. When frame_cnt reaches REVEAL_FRAMES-1 on a tick: frame_cnt=0 and revealed++. Goes to HOLD when revealed reaches COLS.
  - HOLD: all columns are visible; stays here while enable=1.
  - From any state, enable=0 returns to IDLE on the next clock.
- visible(column) = column < revealed.
- revealed saturates at COLS; revealed width is 8 bits.
- Tick and enable drop in the same cycle: enable wins (IDLE).
- revealed changes only at a vblnk rising edge, so there is no mid-frame tearing.
- Reset mid-frame: outputs read 0 until the pipeline refills, 3 cycles after reset release.

Optional Feature:
- Macro: CHAR_BG_EN.
- Defined: in-box, non-lit pixels of visible columns output a fixed 12'h222 box colour.
- Undefined: the overlay is transparent and those pixels pass rgb_in.

Decomposition:
- Package vga_pkg: CHAR_W=8, CHAR_H=16, HCNT_W=11, RGB_W=12, and the FSM state enum {IDLE, REVEAL, HOLD}.
- Sub-module text_reveal_ctrl: vblnk edge detect, frame_cnt, FSM and revealed count. Interface is pclk, rst, enable, vblnk_in → revealed[7:0].

Test Plan:
- Reset asserted mid-line → all outputs 0 immediately; after release, rgb_out follows rgb_in with exactly 3-cycle delay.
- hcount=100, vcount=105, enable high → char_xy=16'h0000 and font_addr={7'h49,4'h5} one cycle later.
- hcount=108 (column 1) → char_xy=16'h0100. hcount=339 (column 29) → 16'h1D00. hcount=340 → char_xy=0, rgb_out=rgb_in.
- Reveal pacing, REVEAL_FRAMES=4: after 8 vblnk edges revealed=2. Column 1 lit pixels show 12'hF00; column 2 passes rgb_in. After 120 edges: HOLD, revealed=30.
- Drop enable during REVEAL → IDLE next clock, revealed=0, no text. Re-assert → reveal restarts from 0.
- Compile with CHAR_BG_EN, char_pixels=8'h00 in box on a visible column → rgb_out=12'h222. Without the macro → rgb_in.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA overlay types: cell geometry, bus widths, reveal FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a; the VGA stream is free-running with no stall path.
package vga_pkg;

    localparam int CHAR_W = 8;   // pixels per character cell, horizontal
    localparam int CHAR_H = 16;  // lines per character cell, vertical
    localparam int HCNT_W = 11;  // width of hcount / vcount
    localparam int RGB_W  = 12;  // RGB444 pixel width

    typedef enum logic [1:0] {
        IDLE,
        REVEAL,
        HOLD
    } reveal_state_t;

    // VGA timing bundle carried down the overlay pipeline.
    typedef struct packed {
        logic [HCNT_W-1:0] hcount;
        logic              hsync;
        logic              hblnk;
        logic [HCNT_W-1:0] vcount;
        logic              vsync;
        logic              vblnk;
    } vga_timing_t;

endpackage

// File: rtl/text_reveal_ctrl.sv
// Typewriter pacing: reveals one more text column every REVEAL_FRAMES frames.
// Latency: revealed updates on the clock after a vblnk_in rising edge or an enable drop.
// Backpressure: none; enable=0 forces IDLE (revealed=0) on the next clock.
// Ports: pclk/rst (async active-high), enable, vblnk_in -> revealed[7:0] (saturates at COLS).
module text_reveal_ctrl
    import vga_pkg::*;
#(
    parameter int COLS          = 30,
    parameter int REVEAL_FRAMES = 4
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       enable,
    input  logic       vblnk_in,
    output logic [7:0] revealed
);

    localparam int              FC_W     = (REVEAL_FRAMES > 1) ? $clog2(REVEAL_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST  = FC_W'(REVEAL_FRAMES - 1);
    localparam logic [7:0]      COLS_SAT = 8'(COLS);

    reveal_state_t   state_q, state_d;
    logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]      revealed_q, revealed_d;
    logic            vblnk_prev_q;
    logic            tick;

    // One tick per frame: the rising edge of vertical blank, so the
    // revealed count never changes inside the visible area.
    assign tick     = vblnk_in & ~vblnk_prev_q;
    assign revealed = revealed_q;

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        revealed_d  = revealed_q;
        // Dropping enable overrides any tick arriving in the same cycle.
        if (!enable) begin
            state_d     = IDLE;
            frame_cnt_d = '0;
            revealed_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    frame_cnt_d = '0;
                    revealed_d  = '0;
                    state_d     = REVEAL;
                end
                REVEAL: begin
                    if (tick) begin
                        if (frame_cnt_q == FC_LAST) begin
                            frame_cnt_d = '0;
                            revealed_d  = revealed_q + 8'd1;
                            if (revealed_q + 8'd1 >= COLS_SAT) begin
                                revealed_d = COLS_SAT;
                                state_d    = HOLD;
                            end
                        end else begin
                            frame_cnt_d = frame_cnt_q + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    revealed_d = COLS_SAT;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            frame_cnt_q  <= '0;
            revealed_q   <= '0;
            vblnk_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            revealed_q   <= revealed_d;
            vblnk_prev_q <= vblnk_in;
        end
    end

endmodule

// File: rtl/cheater_text_overlay.sv
// Text overlay stage: paints a char-ROM message (revealed typewriter-style) over the VGA stream.
// Latency: fixed 3 pclk cycles for all timing outputs and rgb_out.
// Backpressure: none; free-running pixel stream, one pixel per clock.
// Ports: pclk, rst (async active-high), enable; VGA timing + rgb_in in; char_xy -> char ROM
//   (char_code back combinationally); font_addr -> font ROM (char_pixels back one clock later);
//   delayed timing + rgb_out. Build option CHAR_BG_EN: fill unlit cells of visible columns with 12'h222.
module cheater_text_overlay
    import vga_pkg::*;
#(
    parameter int               XPOS          = 100,
    parameter int               YPOS          = 100,
    parameter int               COLS          = 30,
    parameter int               ROWS          = 1,
    parameter logic [RGB_W-1:0] TEXT_COLOR    = 12'hF00,
    parameter int               REVEAL_FRAMES = 4
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              enable,
    input  logic [HCNT_W-1:0] hcount_in,
    input  logic              hsync_in,
    input  logic              hblnk_in,
    input  logic [HCNT_W-1:0] vcount_in,
    input  logic              vsync_in,
    input  logic              vblnk_in,
    input  logic [RGB_W-1:0]  rgb_in,
    input  logic [6:0]        char_code,
    input  logic [7:0]        char_pixels,
    output logic [15:0]       char_xy,
    output logic [10:0]       font_addr,
    output logic [HCNT_W-1:0] hcount_out,
    output logic              hsync_out,
    output logic              hblnk_out,
    output logic [HCNT_W-1:0] vcount_out,
    output logic              vsync_out,
    output logic              vblnk_out,
    output logic [RGB_W-1:0]  rgb_out
);

    // Box bounds widened by one bit so XPOS + box width cannot wrap.
    localparam logic [HCNT_W:0]   X_LO    = (HCNT_W+1)'(XPOS);
    localparam logic [HCNT_W:0]   X_HI    = (HCNT_W+1)'(XPOS + CHAR_W * COLS);
    localparam logic [HCNT_W:0]   Y_LO    = (HCNT_W+1)'(YPOS);
    localparam logic [HCNT_W:0]   Y_HI    = (HCNT_W+1)'(YPOS + CHAR_H * ROWS);
    localparam logic [HCNT_W-1:0] X_LO_NW = HCNT_W'(XPOS);

    typedef struct packed {
        vga_timing_t      tim;
        logic [RGB_W-1:0] rgb;
        logic             in_box;
        logic [2:0]       px;
        logic [7:0]       col;
    } pix_t;

    pix_t              s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [3:0]        s1_line_q, s1_line_d;
    logic [15:0]       char_xy_q, char_xy_d;
    logic [10:0]       font_addr_q, font_addr_d;
    logic [HCNT_W:0]   h_ext, v_ext, rel_y;
    logic [HCNT_W-1:0] rel_x;
    logic              in_box;
    logic [7:0]        revealed;
    logic              visible, lit, blank;

    text_reveal_ctrl #(
        .COLS          (COLS),
        .REVEAL_FRAMES (REVEAL_FRAMES)
    ) u_reveal (
        .pclk     (pclk),
        .rst      (rst),
        .enable   (enable),
        .vblnk_in (vblnk_in),
        .revealed (revealed)
    );

    always_comb begin
        h_ext  = {1'b0, hcount_in};
        v_ext  = {1'b0, vcount_in};
        in_box = (h_ext >= X_LO) && (h_ext < X_HI) && (v_ext >= Y_LO) && (v_ext < Y_HI);
        rel_x  = hcount_in - X_LO_NW;
        rel_y  = v_ext - Y_LO;

        // Stage 1: locate the pixel inside the text box and ask the char ROM.
        s1_d.tim.hcount = hcount_in;
        s1_d.tim.hsync  = hsync_in;
        s1_d.tim.hblnk  = hblnk_in;
        s1_d.tim.vcount = vcount_in;
        s1_d.tim.vsync  = vsync_in;
        s1_d.tim.vblnk  = vblnk_in;
        s1_d.rgb        = rgb_in;
        s1_d.in_box     = in_box;
        s1_d.px         = rel_x[2:0];
        s1_d.col        = rel_x[10:3];
        s1_line_d       = rel_y[3:0];
        char_xy_d       = in_box ? {rel_x[10:3], rel_y[11:4]} : 16'h0000;

        // Stage 2: char ROM answered combinationally; form the font address.
        s2_d        = s1_q;
        font_addr_d = {char_code, s1_line_q};

        // Stage 3: font ROM data lands alongside these registers.
        s3_d = s2_q;
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            s3_q        <= '0;
            s1_line_q   <= '0;
            char_xy_q   <= '0;
            font_addr_q <= '0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            s1_line_q   <= s1_line_d;
            char_xy_q   <= char_xy_d;
            font_addr_q <= font_addr_d;
        end
    end

    assign char_xy    = char_xy_q;
    assign font_addr  = font_addr_q;
    assign hcount_out = s3_q.tim.hcount;
    assign hsync_out  = s3_q.tim.hsync;
    assign hblnk_out  = s3_q.tim.hblnk;
    assign vcount_out = s3_q.tim.vcount;
    assign vsync_out  = s3_q.tim.vsync;
    assign vblnk_out  = s3_q.tim.vblnk;

    // char_pixels is the font ROM's own register output and only becomes valid
    // in the cycle stage 3 holds, so the final mux is combinational off stage 3.
    // Bit 7 is the leftmost pixel: index 7-px, which is ~px for 3 bits.
    always_comb begin
        visible = s3_q.col < revealed;
        lit     = s3_q.in_box && visible && char_pixels[~s3_q.px];
        blank   = s3_q.tim.hblnk || s3_q.tim.vblnk;
        rgb_out = s3_q.rgb;
        if (blank) begin
            rgb_out = '0;
        end else if (lit) begin
            rgb_out = TEXT_COLOR;
        end
`ifdef CHAR_BG_EN
        else if (s3_q.in_box && visible) begin
            rgb_out = 12'h222;
        end
`endif
    end

endmodule
